control_unit_staged: RTL and testbench
======================================

// Module: control_unit_staged
// PURPOSE
//  Registered decode/control stage for the RV32IM pipeline: full RV32IM decode (R, I-ALU, LOAD, STORE,
//  BRANCH, JAL, JALR, LUI, AUIPC) into ID/EX control signals. Adds a valid/ready handshake, downstream
//  stall and flush, and a multi-cycle hold that blocks issue while MUL/DIV-class ops occupy the ALU.
//  Sits between instruction fetch and the ID/EX register; its outputs feed the EX/MEM/WB muxes directly.
// PARAMETERS
//  ALUOP_W     5   ALUOP width; must be >=5, upper bits zero-extended
//  MUL_CYCLES  1   EX cycles for MUL/MULH/MULHSU/MULHU; 1 = no hold; must be >=1
//  DIV_CYCLES  32  EX cycles for DIV/DIVU/REM/REMU; must be >=1
// PORTS
//  CLK          in   1        clock, rising edge
//  RESETN       in   1        asynchronous active-low reset
//  INSTRUCTION  in   32       instruction word from fetch
//  IN_VALID     in   1        INSTRUCTION is valid
//  IN_READY     out  1        stage accepts INSTRUCTION this cycle
//  STALL        in   1        downstream cannot take the current output; hold it
//  FLUSH        in   1        discard held output and any multi-cycle hold
//  OUT_VALID    out  1        outputs below carry a real instruction (0 = bubble)
//  ALUOP        out  ALUOP_W  ALU operation
//  IMME_SELECT  out  3        000 I,001 S,010 B,011 U,100 J,111 none
//  MUX1_SELECT  out  1        ALU A: 0 rs1, 1 PC
//  MUX2_SELECT  out  1        ALU B: 0 rs2, 1 immediate
//  BR_SEL       out  3        000 none,001 BEQ,010 BNE,011 BLT,100 BGE,101 BLTU,110 BGEU,111 jump
//  WRITEENABLE  out  1        register writeback enable
//  MEM_READ     out  2        00 none,01 byte,10 half,11 word
//  MEM_UNSIGNED out  1        zero-extend load (LBU/LHU)
//  MEM_WRITE    out  2        00 none,01 SB,10 SH,11 SW
//  ILLEGAL      out  1        accepted word did not decode
//  BUSY         out  1        multi-cycle hold active
// BEHAVIOUR
//  - Reset (async, RESETN=0): OUT_VALID=0, ALUOP=0 (NOP), IMME_SELECT=111, MUX1/MUX2=0, BR_SEL=000,
//    WRITEENABLE=0, MEM_*=0, ILLEGAL=0, BUSY=0, FSM=RUN, counter=0. Reset mid-hold aborts the hold.
//  - ALUOP: 00000 NOP; 00001..10010 = ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,MUL,MULH,MULHSU,MULHU,
//    DIV,DIVU,REM,REMU; 10011 PASSB (LUI); 10100 LINK (A+4, JAL/JALR with MUX1=1 PC / rs1 resp.).
//    R-type key {funct7,funct3}; M ops funct7=0000001. I-ALU uses funct3; SLLI needs funct7=0000000,
//    SRLI/SRAI funct7 0000000/0100000. LOAD/STORE/BRANCH/AUIPC use ADD; branches MUX1=0,MUX2=0.
//  - IN_READY = !BUSY & !FLUSH & !(OUT_VALID & STALL). Accept = IN_VALID & IN_READY.
//  - Latency 1: accepted word's decode appears on outputs, OUT_VALID=1, at the next edge.
//  - OUT_VALID & STALL & !FLUSH: all outputs hold unchanged.
//  - No accept and no stall: bubble next cycle (OUT_VALID=0, all controls at reset values).
//  - FLUSH (priority over everything except reset): next cycle bubble, FSM=RUN, counter=0, BUSY=0;
//    a word presented with FLUSH is not accepted.
//  - Illegal (unknown opcode/funct): accepted, OUT_VALID=1, ILLEGAL=1, ALUOP=NOP, WRITEENABLE=0,
//    MEM_*=0, BR_SEL=000; no hold.
//  - FSM RUN->HOLD on accept of MUL-class (if MUL_CYCLES>1) or DIV-class (if DIV_CYCLES>1);
//    counter loads N-1. HOLD: BUSY=1, counter decrements every cycle (STALL does not freeze it);
//    counter==1 at edge -> RUN (counter 0). BUSY is registered: high exactly N-1 cycles after accept.
//  - Instruction word fields beyond those decoded (rd/rs) are not interpreted here.
// TESTING
//  - ADD 0x002081B3 accepted -> next cycle OUT_VALID=1, ALUOP=00001, WRITEENABLE=1, MUX2=0, IMME=111.
//  - DIV 0x027342B3, DIV_CYCLES=32 -> ALUOP=01111, BUSY=1 and IN_READY=0 for 31 cycles, then ready.
//  - LW 0x00012083 with STALL=1 next 3 cycles -> MEM_READ=11, MEM_UNSIGNED=0, outputs frozen, IN_READY=0.
//  - BEQ 0x00208463 then FLUSH -> BR_SEL=001 one cycle, then bubble: OUT_VALID=0, BR_SEL=000.
//  - 0xFFFFFFFF accepted -> ILLEGAL=1, OUT_VALID=1, WRITEENABLE=0, MEM_WRITE=00, BUSY=0.
//  - RESETN low during DIV hold -> outputs to reset values immediately; IN_READY=1 after release.

Source files
------------

// File: rtl/control_unit_staged.sv
// control_unit_staged
//   Registered RV32IM decode stage. It turns an accepted instruction word into
//   ID/EX control signals one cycle later. It has a valid/ready handshake, a
//   downstream stall and a flush input. A multi-cycle hold blocks issue while a
//   MUL- or DIV-class op occupies the ALU.
// Ports
//   CLK, RESETN        clock (rising edge), asynchronous active-low reset
//   INSTRUCTION        instruction word from fetch
//   IN_VALID/IN_READY  input handshake; accept = IN_VALID & IN_READY
//   STALL, FLUSH       hold the current output / discard output and any hold
//   OUT_VALID          outputs carry a real instruction (0 = bubble)
//   ALUOP .. MEM_WRITE decoded controls for the EX/MEM/WB muxes
//   ILLEGAL            accepted word did not decode
//   BUSY               multi-cycle hold active
module control_unit_staged #(
    parameter int ALUOP_W    = 5,
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic [31:0]        INSTRUCTION,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic               STALL,
    input  logic               FLUSH,
    output logic               OUT_VALID,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic [2:0]         IMME_SELECT,
    output logic               MUX1_SELECT,
    output logic               MUX2_SELECT,
    output logic [2:0]         BR_SEL,
    output logic               WRITEENABLE,
    output logic [1:0]         MEM_READ,
    output logic               MEM_UNSIGNED,
    output logic [1:0]         MEM_WRITE,
    output logic               ILLEGAL,
    output logic               BUSY
);
    typedef struct packed {
        logic [4:0] aluop;
        logic [2:0] imm;
        logic       mux1;
        logic       mux2;
        logic [2:0] br;
        logic       we;
        logic [1:0] mrd;
        logic       munsigned;
        logic [1:0] mwr;
        logic       ill;
    } ctl_t;

    localparam ctl_t CTL_NOP = '{aluop: 5'd0, imm: 3'b111, mux1: 1'b0, mux2: 1'b0, br: 3'b000,
                                 we: 1'b0, mrd: 2'b00, munsigned: 1'b0, mwr: 2'b00, ill: 1'b0};

    localparam logic [4:0] OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_SLL = 5'd3,  OP_SLT = 5'd4;
    localparam logic [4:0] OP_SLTU = 5'd5, OP_XOR = 5'd6,  OP_SRL = 5'd7,  OP_SRA = 5'd8;
    localparam logic [4:0] OP_OR = 5'd9,   OP_AND = 5'd10, OP_MUL0 = 5'd11, OP_DIV0 = 5'd15;
    localparam logic [4:0] OP_PASSB = 5'd19, OP_LINK = 5'd20;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic MUL_HOLDS = (MUL_CYCLES > 1);
    localparam logic DIV_HOLDS = (DIV_CYCLES > 1);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;
    ctl_t             dec;
    logic             legal, is_mul, is_div, accept;
    ctl_t             ctl_q, ctl_d;
    logic             valid_q, valid_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy;
    logic             unused_fields;

    assign opcode = INSTRUCTION[6:0];
    assign funct3 = INSTRUCTION[14:12];
    assign funct7 = INSTRUCTION[31:25];
    // rd/rs1/rs2 are consumed by the register file, not by this stage.
    assign unused_fields = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

    always_comb begin
        dec    = CTL_NOP;
        legal  = 1'b1;
        is_mul = 1'b0;
        is_div = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.we = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'd0}: dec.aluop = OP_ADD;
                    {7'h20, 3'd0}: dec.aluop = OP_SUB;
                    {7'h00, 3'd1}: dec.aluop = OP_SLL;
                    {7'h00, 3'd2}: dec.aluop = OP_SLT;
                    {7'h00, 3'd3}: dec.aluop = OP_SLTU;
                    {7'h00, 3'd4}: dec.aluop = OP_XOR;
                    {7'h00, 3'd5}: dec.aluop = OP_SRL;
                    {7'h20, 3'd5}: dec.aluop = OP_SRA;
                    {7'h00, 3'd6}: dec.aluop = OP_OR;
                    {7'h00, 3'd7}: dec.aluop = OP_AND;
                    default: begin
                        // M extension: funct3 0..3 multiply family, 4..7 divide family
                        if (funct7 == 7'h01) begin
                            dec.aluop = (funct3[2] ? OP_DIV0 : OP_MUL0) + {3'b000, funct3[1:0]};
                            is_mul    = ~funct3[2];
                            is_div    = funct3[2];
                        end else begin
                            legal = 1'b0;
                        end
                    end
                endcase
            end
            7'b0010011: begin
                dec.we   = 1'b1;
                dec.imm  = 3'b000;
                dec.mux2 = 1'b1;
                case (funct3)
                    3'd0: dec.aluop = OP_ADD;
                    3'd2: dec.aluop = OP_SLT;
                    3'd3: dec.aluop = OP_SLTU;
                    3'd4: dec.aluop = OP_XOR;
                    3'd6: dec.aluop = OP_OR;
                    3'd7: dec.aluop = OP_AND;
                    3'd1: if (funct7 == 7'h00) dec.aluop = OP_SLL; else legal = 1'b0;
                    default: begin
                        if (funct7 == 7'h00)      dec.aluop = OP_SRL;
                        else if (funct7 == 7'h20) dec.aluop = OP_SRA;
                        else                      legal = 1'b0;
                    end
                endcase
            end
            7'b0000011: begin
                dec.aluop = OP_ADD; dec.imm = 3'b000; dec.mux2 = 1'b1; dec.we = 1'b1;
                case (funct3)
                    3'd0: dec.mrd = 2'b01;
                    3'd1: dec.mrd = 2'b10;
                    3'd2: dec.mrd = 2'b11;
                    3'd4: begin dec.mrd = 2'b01; dec.munsigned = 1'b1; end
                    3'd5: begin dec.mrd = 2'b10; dec.munsigned = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            7'b0100011: begin
                dec.aluop = OP_ADD; dec.imm = 3'b001; dec.mux2 = 1'b1;
                case (funct3)
                    3'd0: dec.mwr = 2'b01;
                    3'd1: dec.mwr = 2'b10;
                    3'd2: dec.mwr = 2'b11;
                    default: legal = 1'b0;
                endcase
            end
            7'b1100011: begin
                dec.aluop = OP_ADD; dec.imm = 3'b010;
                case (funct3)
                    3'd0: dec.br = 3'b001;
                    3'd1: dec.br = 3'b010;
                    3'd4: dec.br = 3'b011;
                    3'd5: dec.br = 3'b100;
                    3'd6: dec.br = 3'b101;
                    3'd7: dec.br = 3'b110;
                    default: legal = 1'b0;
                endcase
            end
            7'b1101111: begin
                dec.aluop = OP_LINK; dec.imm = 3'b100; dec.mux1 = 1'b1; dec.mux2 = 1'b1;
                dec.br = 3'b111; dec.we = 1'b1;
            end
            7'b1100111: begin
                dec.aluop = OP_LINK; dec.imm = 3'b000; dec.mux2 = 1'b1;
                dec.br = 3'b111; dec.we = 1'b1;
                if (funct3 != 3'd0) legal = 1'b0;
            end
            7'b0110111: begin
                dec.aluop = OP_PASSB; dec.imm = 3'b011; dec.mux2 = 1'b1; dec.we = 1'b1;
            end
            7'b0010111: begin
                dec.aluop = OP_ADD; dec.imm = 3'b011; dec.mux1 = 1'b1; dec.mux2 = 1'b1; dec.we = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec     = CTL_NOP;
            dec.ill = 1'b1;
            is_mul  = 1'b0;
            is_div  = 1'b0;
        end
    end

    assign accept = IN_VALID & IN_READY;

    // Output register: flush beats stall, stall beats a new accept, otherwise a bubble.
    always_comb begin
        valid_d = 1'b0;
        ctl_d   = CTL_NOP;
        if (FLUSH) begin
            valid_d = 1'b0;
        end else if (valid_q && STALL) begin
            valid_d = valid_q;
            ctl_d   = ctl_q;
        end else if (accept) begin
            valid_d = 1'b1;
            ctl_d   = dec;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            valid_q <= 1'b0;
            ctl_q   <= CTL_NOP;
        end else begin
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
        end
    end

    // Hold FSM: state register
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hold FSM: next state. The counter keeps running under STALL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (FLUSH) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept && is_mul && MUL_HOLDS) begin
                        state_d = HOLD;
                        cnt_d   = MUL_LOAD;
                    end else if (accept && is_div && DIV_HOLDS) begin
                        state_d = HOLD;
                        cnt_d   = DIV_LOAD;
                    end
                end
                default: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Hold FSM: outputs
    always_comb begin
        busy     = (state_q == HOLD);
        IN_READY = !busy && !FLUSH && !(valid_q && STALL);
    end

    assign BUSY         = busy;
    assign OUT_VALID    = valid_q;
    assign ALUOP        = ALUOP_W'(ctl_q.aluop);
    assign IMME_SELECT  = ctl_q.imm;
    assign MUX1_SELECT  = ctl_q.mux1;
    assign MUX2_SELECT  = ctl_q.mux2;
    assign BR_SEL       = ctl_q.br;
    assign WRITEENABLE  = ctl_q.we;
    assign MEM_READ     = ctl_q.mrd;
    assign MEM_UNSIGNED = ctl_q.munsigned;
    assign MEM_WRITE    = ctl_q.mwr;
    assign ILLEGAL      = ctl_q.ill;
endmodule

// File: tb/tb_control_unit_staged.sv
// tb_control_unit_staged
//   Directed and randomized bench for control_unit_staged. A behavioural model
//   predicts the handshake, the decoded controls and the remaining hold cycles.
module tb_control_unit_staged;
    localparam int MUL_C = 3;
    localparam int DIV_C = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] aluop;
        logic [2:0] imm;
        logic       m1;
        logic       m2;
        logic [2:0] br;
        logic       we;
        logic [1:0] mr;
        logic       mu;
        logic [1:0] mw;
        logic       ill;
    } exp_t;

    localparam exp_t BUBBLE = '{valid: 1'b0, aluop: 5'd0, imm: 3'b111, m1: 1'b0, m2: 1'b0,
                                br: 3'b000, we: 1'b0, mr: 2'b00, mu: 1'b0, mw: 2'b00, ill: 1'b0};

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [31:0] INSTRUCTION = 32'h0;
    logic        IN_VALID = 1'b0;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic        IN_READY, OUT_VALID, MUX1_SELECT, MUX2_SELECT, WRITEENABLE;
    logic        MEM_UNSIGNED, ILLEGAL, BUSY;
    logic [4:0]  ALUOP;
    logic [2:0]  IMME_SELECT, BR_SEL;
    logic [1:0]  MEM_READ, MEM_WRITE;

    int   n_vec = 0;
    int   n_fail = 0;
    exp_t m_out = BUBBLE;
    int   busy_left = 0;

    // base integer ALU op per funct3 (ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND)
    logic [4:0] alu_base [8] = '{5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10};
    // branch code per funct3; 0 = not a branch
    logic [2:0] br_map [8] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};

    always #5 CLK = ~CLK;

    control_unit_staged #(.ALUOP_W(5), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .CLK(CLK), .RESETN(RESETN), .INSTRUCTION(INSTRUCTION), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .STALL(STALL), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
        .ALUOP(ALUOP), .IMME_SELECT(IMME_SELECT), .MUX1_SELECT(MUX1_SELECT),
        .MUX2_SELECT(MUX2_SELECT), .BR_SEL(BR_SEL), .WRITEENABLE(WRITEENABLE),
        .MEM_READ(MEM_READ), .MEM_UNSIGNED(MEM_UNSIGNED), .MEM_WRITE(MEM_WRITE),
        .ILLEGAL(ILLEGAL), .BUSY(BUSY));

    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t c;
        logic ok;
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        c = BUBBLE; c.valid = 1'b1; ok = 1'b1;
        case (op)
            7'h33: begin
                c.we = 1'b1;
                if (f7 == 7'h00) c.aluop = alu_base[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) c.aluop = 5'd2;
                else if (f7 == 7'h20 && f3 == 3'd5) c.aluop = 5'd8;
                else if (f7 == 7'h01) c.aluop = 5'd11 + 5'(f3);
                else ok = 1'b0;
            end
            7'h13: begin
                c.we = 1'b1; c.imm = 3'b000; c.m2 = 1'b1;
                c.aluop = alu_base[f3];
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) c.aluop = 5'd8;
                    else ok = (f7 == 7'h00);
                end
            end
            7'h03: begin
                c.aluop = 5'd1; c.imm = 3'b000; c.m2 = 1'b1; c.we = 1'b1;
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ok = 1'b0;
                else begin
                    c.mr = 2'(f3[1:0] + 2'd1);
                    c.mu = f3[2];
                end
            end
            7'h23: begin
                c.aluop = 5'd1; c.imm = 3'b001; c.m2 = 1'b1;
                if (f3 > 3'd2) ok = 1'b0; else c.mw = 2'(f3[1:0] + 2'd1);
            end
            7'h63: begin
                c.aluop = 5'd1; c.imm = 3'b010; c.br = br_map[f3];
                if (br_map[f3] == 3'd0) ok = 1'b0;
            end
            7'h6F: begin c.aluop = 5'd20; c.imm = 3'b100; c.m1 = 1'b1; c.m2 = 1'b1; c.br = 3'b111; c.we = 1'b1; end
            7'h67: begin c.aluop = 5'd20; c.imm = 3'b000; c.m2 = 1'b1; c.br = 3'b111; c.we = 1'b1; ok = (f3 == 3'd0); end
            7'h37: begin c.aluop = 5'd19; c.imm = 3'b011; c.m2 = 1'b1; c.we = 1'b1; end
            7'h17: begin c.aluop = 5'd1; c.imm = 3'b011; c.m1 = 1'b1; c.m2 = 1'b1; c.we = 1'b1; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            c = BUBBLE; c.valid = 1'b1; c.ill = 1'b1;
        end
        return c;
    endfunction

    // cycles the stage stays busy after accepting an op with this decode
    function automatic int hold_len(input exp_t c);
        int n;
        n = 1;
        if (c.aluop >= 5'd11 && c.aluop <= 5'd14) n = MUL_C;
        if (c.aluop >= 5'd15 && c.aluop <= 5'd18) n = DIV_C;
        return n - 1;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0, 1: begin
                w[6:0] = (k == 0) ? 7'h33 : 7'h13;
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h6F;
            6: begin w[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0; end
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        chk(tag, 32'({OUT_VALID, ALUOP, IMME_SELECT, MUX1_SELECT, MUX2_SELECT, BR_SEL, WRITEENABLE,
                      MEM_READ, MEM_UNSIGNED, MEM_WRITE, ILLEGAL, BUSY}),
                 32'({m_out, busy_left != 0}));
    endtask

    // One clock: drive, check ready before the edge, advance the model, check outputs after.
    task automatic step(input string tag, input logic v, input logic [31:0] w,
                        input logic st, input logic fl);
        logic exp_rdy;
        exp_t nxt;
        int   nbl;
        IN_VALID = v; INSTRUCTION = w; STALL = st; FLUSH = fl;
        @(negedge CLK);
        exp_rdy = (busy_left == 0) && !fl && !(m_out.valid && st);
        chk({tag, ":ready"}, 32'(IN_READY), 32'(exp_rdy));
        nbl = (busy_left > 0) ? busy_left - 1 : 0;
        if (fl) begin
            nxt = BUBBLE; nbl = 0;
        end else if (m_out.valid && st) begin
            nxt = m_out;
        end else if (v && exp_rdy) begin
            nxt = ref_dec(w); nbl = hold_len(nxt);
        end else begin
            nxt = BUBBLE;
        end
        @(posedge CLK); #1;
        m_out = nxt; busy_left = nbl;
        chk_out({tag, ":out"});
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk_out("reset");
        chk("reset_ready", 32'(IN_READY), 32'd1);
        RESETN = 1'b1;

        step("add", 1'b1, 32'h002081B3, 1'b0, 1'b0);
        chk("add_aluop", 32'(ALUOP), 32'd1);
        chk("add_we", 32'(WRITEENABLE), 32'd1);

        step("div", 1'b1, 32'h027342B3, 1'b0, 1'b0);
        chk("div_aluop", 32'(ALUOP), 32'd15);
        for (int i = 0; i < DIV_C - 1; i++) step("div_hold", 1'b1, 32'h002081B3, 1'b0, 1'b0);
        chk("div_done_busy", 32'(BUSY), 32'd0);
        step("after_div", 1'b1, 32'h002081B3, 1'b0, 1'b0);

        step("lw", 1'b1, 32'h00012083, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("lw_stall", 1'b1, 32'h002081B3, 1'b1, 1'b0);
        chk("lw_mem_read", 32'(MEM_READ), 32'd3);
        step("lw_release", 1'b0, 32'h0, 1'b0, 1'b0);

        step("beq", 1'b1, 32'h00208463, 1'b0, 1'b0);
        chk("beq_br", 32'(BR_SEL), 32'd1);
        step("beq_flush", 1'b1, 32'h002081B3, 1'b0, 1'b1);
        chk("flush_br", 32'(BR_SEL), 32'd0);

        step("illegal", 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("illegal_flag", 32'(ILLEGAL), 32'd1);

        step("mul", 1'b1, 32'h027302B3, 1'b0, 1'b0);
        step("mul_hold", 1'b1, 32'h002081B3, 1'b1, 1'b0);
        step("mul_hold2", 1'b1, 32'h002081B3, 1'b0, 1'b0);
        step("mul_next", 1'b1, 32'h002081B3, 1'b0, 1'b0);

        step("div_flush", 1'b1, 32'h027352B3, 1'b0, 1'b0);
        step("div_flush2", 1'b0, 32'h0, 1'b0, 1'b0);
        step("div_flush3", 1'b1, 32'h002081B3, 1'b0, 1'b1);
        step("div_flush4", 1'b1, 32'h002081B3, 1'b0, 1'b0);

        // reset in the middle of a divide hold
        step("div_rst", 1'b1, 32'h027342B3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("div_rst_hold", 1'b0, 32'h0, 1'b0, 1'b0);
        IN_VALID = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
        #2;
        RESETN = 1'b0;
        #1;
        m_out = BUBBLE; busy_left = 0;
        chk_out("async_reset");
        chk("async_reset_ready", 32'(IN_READY), 32'd1);
        @(posedge CLK); #1;
        RESETN = 1'b1;
        step("post_reset", 1'b1, 32'h002081B3, 1'b0, 1'b0);

        for (int i = 0; i < 800; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), rand_instr(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
